// File: rtl/min_max_array_loader.sv
// Streams N_WORDS bytes into the min/max finder array, then starts it and waits for done.
// Latency: a write reaches the finder on the transfer edge; Start rises the clock after the last transfer.
// Backpressure: In_ready is high only in LOAD; the source must hold bytes while it is low.
module min_max_array_loader #(
  parameter int N_WORDS = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic              M_wr_en,
  output logic [ADDR_W-1:0] M_wr_addr,
  output logic [DATA_W-1:0] M_wr_data,
  output logic              Start,
  input  logic              Done_in,
  output logic              Ack,
  output logic [7:0]        Batch_cnt,
  output logic              Qi,
  output logic              Ql,
  output logic              Qs,
  output logic              Qw,
  output logic              Qa
);

  typedef enum logic [2:0] {
    S_INI  = 3'd0,
    S_LOAD = 3'd1,
    S_STRT = 3'd2,
    S_WAIT = 3'd3,
    S_ACKS = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        batch_q, batch_d;

  // State, index and batch counter registers; reset abandons any partial batch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INI;
      idx_q   <= '0;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      batch_q <= batch_d;
    end
  end

  // Next-state logic: load N_WORDS bytes, pulse Start, wait for Done, pulse Ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    batch_d = batch_q;
    unique case (state_q)
      S_INI: begin
        idx_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (In_valid) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_STRT;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      // Done_in is not looked at here: the previous batch's DONE may still be high.
      S_STRT: state_d = S_WAIT;
      S_WAIT: begin
        if (Done_in) begin
          batch_d = batch_q + 8'd1;
          state_d = S_ACKS;
        end
      end
      S_ACKS: state_d = S_INI;
      default: state_d = S_INI;
    endcase
  end

  // Moore decode of state flags and handshakes; the write port passes straight through.
  always_comb begin
    Qi        = (state_q == S_INI);
    Ql        = (state_q == S_LOAD);
    Qs        = (state_q == S_STRT);
    Qw        = (state_q == S_WAIT);
    Qa        = (state_q == S_ACKS);
    In_ready  = Ql;
    Start     = Qs;
    Ack       = Qa;
    M_wr_en   = Ql & In_valid;
    M_wr_addr = idx_q;
    M_wr_data = In_data;
    Batch_cnt = batch_q;
  end

endmodule

// File: tb/tb_min_max_array_loader.sv
// Self-checking bench for min_max_array_loader with a small finder model on the write port.
// Inputs driven on the falling edge, outputs sampled 1ns later.
// Bench reference: expected write order, Start latency, batch count and min/max from plain arithmetic.
module tb_min_max_array_loader;

  logic       Clk;
  logic       Reset;
  logic [7:0] In_data;
  logic       In_valid;
  logic       In_ready;
  logic       M_wr_en;
  logic [3:0] M_wr_addr;
  logic [7:0] M_wr_data;
  logic       Start;
  logic       Done_in;
  logic       Ack;
  logic [7:0] Batch_cnt;
  logic       Qi, Ql, Qs, Qw, Qa;

  int checks = 0;
  int errors = 0;
  int exp_batch = 0;
  bit mon_en = 0;

  min_max_array_loader #(.N_WORDS(16), .ADDR_W(4), .DATA_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
    .M_wr_en(M_wr_en), .M_wr_addr(M_wr_addr), .M_wr_data(M_wr_data), .Start(Start),
    .Done_in(Done_in), .Ack(Ack), .Batch_cnt(Batch_cnt),
    .Qi(Qi), .Ql(Ql), .Qs(Qs), .Qw(Qw), .Qa(Qa)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  // Exactly one state flag high on every clock once reset has been applied.
  always @(negedge Clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot({Qi, Ql, Qs, Qw, Qa})) begin
        errors++;
        $display("FAIL onehot got %b required exactly one bit set", {Qi, Ql, Qs, Qw, Qa});
      end
    end
  end

  // Drives one full batch and plays the finder; mx/mn are what the finder would report.
  task automatic run_batch(input logic [7:0] d[16], input int mode, input int exp_lat,
                           input bit stale, input int dly,
                           output logic [7:0] mx, output logic [7:0] mn);
    logic [7:0] cap[16];
    int k = 0, cyc = 0, first = -1, b = 0;
    bit v;
    mx = 8'h00;
    mn = 8'hFF;
    @(negedge Clk); In_valid = 1; In_data = d[0]; Done_in = 0; #1;
    while (!Ql && b < 8) begin
      checks++;
      if (In_ready !== 0 || M_wr_en !== 0 || Start !== 0 || Ack !== 0 || Batch_cnt !== 8'(exp_batch)) begin
        errors++;
        $display("FAIL ini_outputs got rdy=%b wr=%b st=%b ack=%b cnt=%0d required 0 0 0 0 %0d",
                 In_ready, M_wr_en, Start, Ack, Batch_cnt, exp_batch);
      end
      @(negedge Clk); #1; b++;
    end
    checks++;
    if (!Ql) begin
      errors++;
      $display("FAIL load_timeout got Ql=%b required 1 within 8 clocks", Ql);
      return;
    end
    while (k < 16 && cyc < 200) begin
      case (mode)
        0:       v = 1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      In_valid = v;
      In_data  = v ? d[k] : 8'($urandom);
      #1;
      checks++;
      if (Ql !== 1 || In_ready !== 1 || Start !== 0 || M_wr_en !== v) begin
        errors++;
        $display("FAIL load_cycle got Ql=%b rdy=%b st=%b wr=%b required 1 1 0 %b", Ql, In_ready, Start, M_wr_en, v);
      end
      if (v) begin
        checks++;
        if (M_wr_addr !== 4'(k) || M_wr_data !== d[k]) begin
          errors++;
          $display("FAIL write_port got addr=%0d data=%h required addr=%0d data=%h", M_wr_addr, M_wr_data, k, d[k]);
        end
        if (M_wr_en === 1) cap[M_wr_addr] = M_wr_data;
        if (first < 0) first = cyc;
        k++;
      end
      cyc++;
      @(negedge Clk);
    end
    // Start cycle: source keeps offering a byte that must not be consumed.
    In_valid = 1; In_data = 8'($urandom); Done_in = stale; #1;
    checks++;
    if (Start !== 1 || Qs !== 1 || In_ready !== 0 || M_wr_en !== 0 || Ack !== 0) begin
      errors++;
      $display("FAIL start_pulse got st=%b Qs=%b rdy=%b wr=%b ack=%b required 1 1 0 0 0", Start, Qs, In_ready, M_wr_en, Ack);
    end
    if (exp_lat >= 0) begin
      checks++;
      if (cyc - first !== exp_lat) begin
        errors++;
        $display("FAIL start_latency got %0d required %0d", cyc - first, exp_lat);
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (cap[i] > mx) mx = cap[i];
      if (cap[i] < mn) mn = cap[i];
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge Clk); Done_in = 0; #1;
      checks++;
      if (Qw !== 1 || Start !== 0 || Ack !== 0 || In_ready !== 0 || M_wr_en !== 0) begin
        errors++;
        $display("FAIL wait_hold got Qw=%b st=%b ack=%b rdy=%b wr=%b required 1 0 0 0 0", Qw, Start, Ack, In_ready, M_wr_en);
      end
    end
    @(negedge Clk); Done_in = 1; #1;
    checks++;
    if (Qw !== 1 || Ack !== 0) begin
      errors++;
      $display("FAIL wait_done got Qw=%b ack=%b required 1 0", Qw, Ack);
    end
    @(negedge Clk); #1;
    exp_batch = (exp_batch + 1) % 256;
    checks++;
    if (Ack !== 1 || Qa !== 1 || Batch_cnt !== 8'(exp_batch) || In_ready !== 0 || Start !== 0) begin
      errors++;
      $display("FAIL ack_pulse got ack=%b Qa=%b cnt=%0d rdy=%b st=%b required 1 1 %0d 0 0",
               Ack, Qa, Batch_cnt, In_ready, Start, exp_batch);
    end
    Done_in = 1;
  endtask

  task automatic test_reset();
    Reset = 1; In_valid = 1; In_data = 8'h55; Done_in = 1;
    @(negedge Clk); @(negedge Clk); #1;
    checks++;
    if (Qi !== 1 || In_ready !== 0 || M_wr_en !== 0 || Start !== 0 || Ack !== 0 || Batch_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state got Qi=%b rdy=%b wr=%b st=%b ack=%b cnt=%0d required 1 0 0 0 0 0",
               Qi, In_ready, M_wr_en, Start, Ack, Batch_cnt);
    end
    mon_en = 1;
    Reset = 0; Done_in = 0; exp_batch = 0;
  endtask

  task automatic test_basic();
    logic [7:0] d[16] = '{8'h3B, 8'h9A, 8'h64, 8'hF4, 8'h90, 8'h83, 8'h23, 8'hF4,
                          8'hF4, 8'h85, 8'h02, 8'h99, 8'h02, 8'h02, 8'h84, 8'hF5};
    logic [7:0] mx, mn;
    run_batch(d, 0, 16, 0, 2, mx, mn);
    checks++;
    if (mx !== 8'hF5 || mn !== 8'h02 || Batch_cnt !== 8'd1) begin
      errors++;
      $display("FAIL basic_minmax got max=%h min=%h cnt=%0d required F5 02 1", mx, mn, Batch_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] d[16] = '{8'h3B, 8'h9A, 8'h64, 8'hF4, 8'h90, 8'h83, 8'h23, 8'hF4,
                          8'hF4, 8'h85, 8'h02, 8'h99, 8'h02, 8'h02, 8'h84, 8'hF5};
    logic [7:0] mx, mn;
    run_batch(d, 1, 31, 0, 1, mx, mn);
    checks++;
    if (mx !== 8'hF5 || mn !== 8'h02) begin
      errors++;
      $display("FAIL gaps_minmax got max=%h min=%h required F5 02", mx, mn);
    end
  endtask

  task automatic test_stale_done();
    logic [7:0] d[16];
    logic [7:0] mx, mn;
    for (int i = 0; i < 16; i++) d[i] = 8'(i * 7 + 1);
    run_batch(d, 0, 16, 1, 3, mx, mn);
    checks++;
    if (Batch_cnt !== 8'(exp_batch) || mx !== 8'd106 || mn !== 8'd1) begin
      errors++;
      $display("FAIL stale_done got cnt=%0d max=%0d min=%0d required %0d 106 1", Batch_cnt, mx, mn, exp_batch);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d[16];
    logic [7:0] mx, mn;
    int b = 0;
    @(negedge Clk); In_valid = 1; Done_in = 0; #1;
    while (!Ql && b < 8) begin @(negedge Clk); #1; b++; end
    for (int i = 0; i < 7; i++) begin
      In_data = 8'($urandom);
      @(negedge Clk);
    end
    Reset = 1; In_valid = 1; In_data = 8'hEE; #1;
    checks++;
    if (M_wr_addr !== 4'd7 || M_wr_en !== 1) begin
      errors++;
      $display("FAIL mid_partial got addr=%0d wr=%b required 7 1", M_wr_addr, M_wr_en);
    end
    @(negedge Clk); Reset = 0; #1;
    exp_batch = 0;
    checks++;
    if (Qi !== 1 || Batch_cnt !== 0 || Start !== 0 || Ack !== 0) begin
      errors++;
      $display("FAIL mid_reset got Qi=%b cnt=%0d st=%b ack=%b required 1 0 0 0", Qi, Batch_cnt, Start, Ack);
    end
    for (int i = 0; i < 16; i++) d[i] = 8'(8'h82 - i);
    run_batch(d, 0, 16, 0, 1, mx, mn);
    checks++;
    if (mx !== 8'h82 || mn !== 8'h73) begin
      errors++;
      $display("FAIL mid_reload got max=%h min=%h required 82 73", mx, mn);
    end
  endtask

  // run_batch keeps In_valid high through STRT/WAIT/ACKS; the next load must still begin at address 0.
  task automatic test_wait_valid();
    logic [7:0] d[16];
    logic [7:0] mx, mn;
    for (int i = 0; i < 16; i++) d[i] = 8'(8'h40 + ((i * 5) % 16));
    run_batch(d, 2, -1, 0, 5, mx, mn);
    checks++;
    if (mx !== 8'h4F || mn !== 8'h40) begin
      errors++;
      $display("FAIL wait_valid got max=%h min=%h required 4F 40", mx, mn);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[16];
    logic [7:0] mx, mn, rmx, rmn;
    @(negedge Clk); Reset = 1; In_valid = 0; Done_in = 0;
    @(negedge Clk); Reset = 0;
    exp_batch = 0;
    for (int n = 0; n < 256; n++) begin
      rmx = 8'h00; rmn = 8'hFF;
      for (int i = 0; i < 16; i++) begin
        d[i] = 8'($urandom);
        if (d[i] > rmx) rmx = d[i];
        if (d[i] < rmn) rmn = d[i];
      end
      run_batch(d, (n % 3 == 0) ? 2 : 0, (n % 3 == 0) ? -1 : 16, n[0], $urandom_range(1, 3), mx, mn);
      checks++;
      if (mx !== rmx || mn !== rmn) begin
        errors++;
        $display("FAIL b2b_minmax batch %0d got max=%h min=%h required %h %h", n, mx, mn, rmx, rmn);
      end
    end
    checks++;
    if (Batch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_wrap got cnt=%0d required 0", Batch_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_stale_done();
    test_mid_reset();
    test_wait_valid();
    test_back_to_back();
    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/min_max_array_loader.md
Name: min_max_array_loader

Overview:
- Upstream feeder for the 16x8 min/max finder.
- Accepts a stream of bytes over a valid/ready handshake and writes them into the finder's array through a write port, one byte per transfer.
- After the last byte it pulses Start for one clock, waits for the finder's Done, then acks the finder and returns for the next batch.
- Keeps a batch counter for throughput checks.

Parameters:
N_WORDS, 16, number of array entries per batch.
ADDR_W, 4, width of array index; must satisfy 2^ADDR_W >= N_WORDS.
DATA_W, 8, byte width, unsigned.

Ports:
Clk  in  1  system clock; all state changes on posedge.
Reset  in  1  synchronous, active-high reset.
In_data  in  DATA_W  incoming array element.
In_valid  in  1  source has a byte on In_data.
In_ready  out  1  loader can accept a byte this clock.
M_wr_en  out  1  write strobe to finder array.
M_wr_addr  out  ADDR_W  write index.
M_wr_data  out  DATA_W  write data.
Start  out  1  one-clock start pulse to finder.
Done_in  in  1  finder DONE state flag (its Qd).
Ack  out  1  one-clock acknowledge to finder, releases it from DONE.
Batch_cnt  out  8  completed batches, wraps 255->0.
Qi, Ql, Qs, Qw, Qa  out  1 each  one-hot state: INI, LOAD, STRT, WAIT, ACKS.

Behaviour:
- Reset (synchronous): state=INI, I=0, Batch_cnt=0.
  - With state=INI, the Moore outputs give In_ready=0, M_wr_en=0, Start=0, Ack=0.
- Outputs decoded combinationally from state only (Moore), except the write-port passthrough below.
- INI: I<=0; unconditionally go to LOAD next clock. In_ready=0.
- LOAD: In_ready=1.
  - A transfer occurs on a posedge where In_valid=1 and In_ready=1.
  - Write port is zero-latency passthrough: M_wr_en = Ql & In_valid, M_wr_addr = I, M_wr_data = In_data. The finder samples the write on the same edge.
  - On a transfer, I<=I+1.
  - If I==N_WORDS-1 at the transfer, go to STRT; I wraps to 0.
  - If In_valid=0, no write and I holds. Stalls of any length are allowed.
- Element order: first byte written to M[0], last to M[N_WORDS-1].
- STRT: Start=1 for exactly one clock; In_ready=0; go to WAIT.
  - Done_in is ignored in STRT, because a stale DONE from the previous batch may still be high.
- WAIT: In_ready=0.
  - Stays until Done_in=1, then goes to ACKS and Batch_cnt<=Batch_cnt+1 (mod 256).
- ACKS: Ack=1 for exactly one clock; go to INI.
- Minimum latency, first byte accepted to Start high: N_WORDS clocks when In_valid is held high (Start asserted the clock after the 16th transfer).
- Bytes presented while In_ready=0 are not consumed; the source must hold them.
- Reset mid-batch (any state): partial data abandoned, I=0, Batch_cnt=0, no Start/Ack emitted. Array contents in the finder are not cleared.
- Reset asserted in the same clock as a transfer: reset wins. Write strobe may still reach the finder that edge, but I is not advanced.
- Exactly one state flag is high at all times after the first reset clock.

Test Plan:
- Reset 2 clocks, then In_valid held 1 with bytes 3B,9A,64,F4,90,83,23,F4,F4,85,02,99,02,02,84,F5 -> 16 writes at addr 0..15 on consecutive clocks; Start one clock after last write; finder reports Max F5, Min 02; Ack one clock; Batch_cnt=1.
- Same data with In_valid low every other clock -> writes only on valid clocks, addresses still 0..15 in order; Start 31 clocks after first transfer.
- Done_in held high during STRT (stale) -> loader still enters WAIT, does not ack until Done_in seen in WAIT; no double Batch_cnt increment.
- Reset asserted after 7 writes -> state INI, I=0, no Start. New batch 82,81,...,73 fully loaded -> finder gives Max 82, Min 73.
- In_valid=1 throughout WAIT -> In_ready stays 0, M_wr_en=0, no address advance until the next LOAD.
- 256 back-to-back batches -> Batch_cnt wraps to 0; one-hot state invariant holds every clock.
